// File: rtl/pes_crc_pkg.sv
// Shared definitions for the streaming CRC generator.
//  - state_t    : FSM encoding of pes_crc_stream_gen (IDLE / PASS / APPEND)
//  - CRC16_8005, CRC16_1021, CRC32_04C11DB7 : common generator polynomials in
//    normal (non-reflected) form, with the implicit x^CRC_W term omitted.
package pes_crc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,   // waiting for the first beat of a frame
        ST_PASS   = 2'd1,   // forwarding payload beats of a frame
        ST_APPEND = 2'd2    // emitting the CRC words after the last payload beat
    } state_t;

    localparam logic [15:0] CRC16_8005     = 16'h8005;
    localparam logic [15:0] CRC16_1021     = 16'h1021;
    localparam logic [31:0] CRC32_04C11DB7 = 32'h04C1_1DB7;

endpackage : pes_crc_pkg

// File: rtl/pes_crc_step.sv
// One data-word step of a serial (MSB-first) CRC LFSR, fully combinational.
// Ports:
//  crc_i  [CRC_W-1:0]   current CRC register
//  data_i [DATA_W-1:0]  data word, bit DATA_W-1 shifted in first
//  crc_o  [CRC_W-1:0]   CRC register after DATA_W shift iterations
module pes_crc_step #(
    parameter int unsigned       DATA_W = 8,
    parameter int unsigned       CRC_W  = 16,
    parameter logic [CRC_W-1:0]  POLY   = 16'h8005
) (
    input  logic [CRC_W-1:0]  crc_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [CRC_W-1:0]  crc_o
);

    logic [CRC_W-1:0] c;
    logic             fb;

    // Unrolled bit-serial LFSR: feedback is the outgoing MSB XOR the next data bit.
    always_comb begin
        c  = crc_i;
        fb = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = c[CRC_W-1] ^ data_i[i];
            c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        crc_o = c;
    end

endmodule : pes_crc_step

// File: rtl/pes_crc_stream_gen.sv
// Streaming CRC generator. Payload words pass through unchanged; after the
// word flagged in_last, the final CRC (crc_reg ^ XOR_OUT) is appended MSB-first
// as NW = CRC_W/DATA_W extra words, the last of which carries out_last.
// CRC_W must be an integer multiple of DATA_W.
//
// Handshake (both ports): a beat transfers on a rising clk edge where
// valid && ready. Sources hold data/last stable while valid && !ready; valid
// never waits for ready, and ready never depends on valid.
//
// Ports:
//  clk, rst            single clock, synchronous active-high reset
//  in_valid/in_ready   input stream handshake
//  in_data, in_last    payload word (MSB processed first), end-of-frame flag
//  out_valid/out_ready output stream handshake
//  out_data, out_last  payload or CRC word, flag on final CRC word
//  crc_value           final CRC of the most recent completed frame
//  crc_done            one-cycle pulse when crc_value is updated
//  dbg_state_o         current FSM state
module pes_crc_stream_gen
    import pes_crc_pkg::*;
#(
    parameter int unsigned       DATA_W  = 8,
    parameter int unsigned       CRC_W   = 16,
    parameter logic [CRC_W-1:0]  POLY    = CRC16_8005,
    parameter logic [CRC_W-1:0]  INIT    = '0,
    parameter logic [CRC_W-1:0]  XOR_OUT = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [CRC_W-1:0]  crc_value,
    output logic              crc_done,
    output state_t            dbg_state_o
);

    localparam int unsigned       NW       = CRC_W / DATA_W;
    localparam int unsigned       CNT_W    = $clog2(NW) + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NW - 1);

    state_t              state_q, state_d;
    logic [CRC_W-1:0]    crc_q, crc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_last_q, out_last_d;
    logic [CRC_W-1:0]    crc_value_q, crc_value_d;
    logic                crc_done_q, crc_done_d;

    logic                slot_free;
    logic                accept;
    logic [CRC_W-1:0]    step_in, step_out;
    logic [CRC_W-1:0]    crc_fin, crc_shift;
    logic [DATA_W-1:0]   append_word;

    // The output register can take a new beat when empty or being drained.
    assign slot_free = !out_valid_q || out_ready;
    assign in_ready  = (state_q != ST_APPEND) && slot_free;
    assign accept    = in_valid && in_ready;

    // First beat of a frame always starts from INIT.
    assign step_in = (state_q == ST_IDLE) ? INIT : crc_q;

    pes_crc_step #(
        .DATA_W (DATA_W),
        .CRC_W  (CRC_W),
        .POLY   (POLY)
    ) u_step (
        .crc_i  (step_in),
        .data_i (in_data),
        .crc_o  (step_out)
    );

    // Word cnt_q of the final CRC, counted from the MSB end.
    assign crc_fin     = crc_q ^ XOR_OUT;
    assign crc_shift   = crc_fin << (int'(cnt_q) * DATA_W);
    assign append_word = crc_shift[CRC_W-1 -: DATA_W];

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        crc_value_d = crc_value_q;
        crc_done_d  = 1'b0;

        // Slot drains this cycle; it stays empty unless reloaded below.
        if (slot_free) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        unique case (state_q)
            ST_IDLE, ST_PASS: begin
                if (accept) begin
                    out_data_d  = in_data;
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    crc_d       = step_out;
                    state_d     = in_last ? ST_APPEND : ST_PASS;
                end
            end
            ST_APPEND: begin
                if (slot_free) begin
                    out_data_d  = append_word;
                    out_valid_d = 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        out_last_d  = 1'b1;
                        cnt_d       = '0;
                        crc_d       = INIT;
                        state_d     = ST_IDLE;
                        crc_value_d = crc_fin;
                        crc_done_d  = 1'b1;
                    end else begin
                        out_last_d  = 1'b0;
                        cnt_d       = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            crc_q       <= INIT;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            crc_value_q <= '0;
            crc_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            crc_value_q <= crc_value_d;
            crc_done_q  <= crc_done_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_last    = out_last_q;
    assign crc_value   = crc_value_q;
    assign crc_done    = crc_done_q;
    assign dbg_state_o = state_q;

endmodule : pes_crc_stream_gen

// File: tb/tb_pes_crc_stream_gen.sv
// Bench for pes_crc_stream_gen: instance 0 is the default CRC-16/8005 engine,
// instance 1 is a CRC-32/BZIP2 configuration. Expected beats and CRC values
// come from a byte-wise reference CRC over the whole frame.
module tb_pes_crc_stream_gen;
  import pes_crc_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals (index 0: CRC16, 1: CRC32) ----------------
  logic        in_valid [2];
  logic        in_ready [2];
  logic [7:0]  in_data  [2];
  logic        in_last  [2];
  logic        out_valid[2];
  logic        out_ready[2] = '{1'b1, 1'b1};
  logic [7:0]  out_data [2];
  logic        out_last [2];
  logic        crc_done [2];
  state_t      dbg_state[2];
  logic [15:0] crc_value16;
  logic [31:0] crc_value32;

  pes_crc_stream_gen #(
    .DATA_W(8), .CRC_W(16), .POLY(CRC16_8005), .INIT(16'h0000), .XOR_OUT(16'h0000)
  ) u_dut16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_last(in_last[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .out_last(out_last[0]),
    .crc_value(crc_value16), .crc_done(crc_done[0]), .dbg_state_o(dbg_state[0])
  );

  pes_crc_stream_gen #(
    .DATA_W(8), .CRC_W(32), .POLY(CRC32_04C11DB7), .INIT(32'hFFFF_FFFF), .XOR_OUT(32'hFFFF_FFFF)
  ) u_dut32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_last(in_last[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .out_last(out_last[1]),
    .crc_value(crc_value32), .crc_done(crc_done[1]), .dbg_state_o(dbg_state[1])
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [8:0]  exp_q0[$];     // {last, data}
  logic [8:0]  exp_q1[$];
  logic [31:0] exp_crc0[$];
  logic [31:0] exp_crc1[$];
  int          frames_exp[2] = '{0, 0};
  int          done_cnt[2]   = '{0, 0};
  bit          rand_ready = 1'b0;
  logic [7:0]  frame_buf[$];

  // ---------------- reference model ----------------
  // Byte-at-a-time CRC: XOR the byte into the top of the register, then
  // eight polynomial-division shifts.
  function automatic logic [31:0] ref_crc(input int w, input logic [31:0] poly,
                                          input logic [31:0] init, input logic [31:0] xo);
    logic [31:0] c, mask, top;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    top  = 32'h1 << (w - 1);
    c    = init;
    foreach (frame_buf[k]) begin
      c = c ^ ({24'h0, frame_buf[k]} << (w - 8));
      for (int b = 0; b < 8; b++) begin
        if ((c & top) != 0) c = ((c << 1) ^ poly) & mask;
        else                c = (c << 1) & mask;
      end
    end
    return (c ^ xo) & mask;
  endfunction

  function automatic logic [31:0] model_crc(input int sel);
    if (sel == 0) return ref_crc(16, 32'h0000_8005, 32'h0, 32'h0);
    else          return ref_crc(32, 32'h04C1_1DB7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
  endfunction

  function automatic void push_exp(input int sel, input logic [8:0] v);
    if (sel == 0) exp_q0.push_back(v);
    else          exp_q1.push_back(v);
  endfunction

  // ---------------- out_ready driver ----------------
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++)
      out_ready[i] = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- driver tasks ----------------
  // Tasks start and end at posedge+1.
  task automatic drive_beat(input int sel, input logic [7:0] d, input bit last, input bit gap);
    int guard;
    if (gap) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    in_valid[sel] = 1'b1;
    in_data[sel]  = d;
    in_last[sel]  = last;
    guard = 0;
    @(negedge clk);
    while (!in_ready[sel] && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) begin
      checks++; failures++;
      $display("FAIL drive_timeout dut%0d in_ready stayed 0, want 1 within 500 cycles", sel);
    end
    @(posedge clk); #1;
    in_valid[sel] = 1'b0;
    in_data[sel]  = 8'($urandom_range(0, 255));  // junk while not valid
    in_last[sel]  = 1'($urandom_range(0, 1));
  endtask

  task automatic send_buf(input int sel, input bit gap);
    int n, w;
    logic [31:0] crcv;
    n = frame_buf.size();
    for (int k = 0; k < n; k++) begin
      drive_beat(sel, frame_buf[k], (k == n - 1), gap);
      push_exp(sel, {1'b0, frame_buf[k]});
    end
    w    = (sel == 0) ? 16 : 32;
    crcv = model_crc(sel);
    for (int k = 0; k < w / 8; k++)
      push_exp(sel, {(k == w / 8 - 1), 8'(crcv >> (w - 8 - 8 * k))});
    if (sel == 0) exp_crc0.push_back(crcv);
    else          exp_crc1.push_back(crcv);
    frames_exp[sel]++;
  endtask

  task automatic load_check_string();
    frame_buf = {};
    for (int c = 8'h31; c <= 8'h39; c++) frame_buf.push_back(8'(c));
  endtask

  task automatic load_random();
    frame_buf = {};
    repeat ($urandom_range(1, 12)) frame_buf.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && g < 2000) begin
      @(posedge clk); #1;
      g++;
    end
    checks++;
    if (g >= 2000) begin
      failures++;
      $display("FAIL drain left q0=%0d q1=%0d beats, want 0", exp_q0.size(), exp_q1.size());
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  bit         hold_v[2] = '{1'b0, 1'b0};
  logic [7:0] held_d[2];
  logic       held_l[2];

  always @(negedge clk) begin
    logic [8:0]  e;
    logic [31:0] ec, ac;
    bit          has;
    if (rst) begin
      hold_v[0] = 1'b0;
      hold_v[1] = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (hold_v[i]) begin
          checks++;
          if (!out_valid[i] || out_data[i] !== held_d[i] || out_last[i] !== held_l[i]) begin
            failures++;
            $display("FAIL stall_stable dut%0d got v=%0b d=%02h l=%0b want v=1 d=%02h l=%0b",
                     i, out_valid[i], out_data[i], out_last[i], held_d[i], held_l[i]);
          end
        end
        if (out_valid[i] && out_ready[i]) begin
          hold_v[i] = 1'b0;
          has = (i == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
          checks++;
          if (!has) begin
            failures++;
            $display("FAIL unexpected_beat dut%0d got d=%02h l=%0b want no beat",
                     i, out_data[i], out_last[i]);
          end else begin
            if (i == 0) e = exp_q0.pop_front();
            else        e = exp_q1.pop_front();
            if ({out_last[i], out_data[i]} !== e) begin
              failures++;
              $display("FAIL out_beat dut%0d got d=%02h l=%0b want d=%02h l=%0b",
                       i, out_data[i], out_last[i], e[7:0], e[8]);
            end
          end
        end else if (out_valid[i]) begin
          hold_v[i] = 1'b1;
          held_d[i] = out_data[i];
          held_l[i] = out_last[i];
        end else begin
          hold_v[i] = 1'b0;
        end
        if (crc_done[i]) begin
          done_cnt[i]++;
          ac  = (i == 0) ? {16'h0, crc_value16} : crc_value32;
          has = (i == 0) ? (exp_crc0.size() != 0) : (exp_crc1.size() != 0);
          checks++;
          if (!has) begin
            failures++;
            $display("FAIL unexpected_done dut%0d got crc 0x%0h want no crc_done", i, ac);
          end else begin
            if (i == 0) ec = exp_crc0.pop_front();
            else        ec = exp_crc1.pop_front();
            if (ac !== ec) begin
              failures++;
              $display("FAIL crc_value dut%0d got 0x%0h want 0x%0h", i, ac, ec);
            end
          end
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog simulation did not complete, want completion before 50000 cycles");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int g;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0;
      in_data[i]  = 8'h00;
      in_last[i]  = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // Reset state of both instances.
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_out_valid%0d", i), 32'(out_valid[i]), 32'h0);
      check($sformatf("rst_out_data%0d", i),  32'(out_data[i]),  32'h0);
      check($sformatf("rst_out_last%0d", i),  32'(out_last[i]),  32'h0);
      check($sformatf("rst_crc_done%0d", i),  32'(crc_done[i]),  32'h0);
      check($sformatf("rst_in_ready%0d", i),  32'(in_ready[i]),  32'h1);
      check($sformatf("rst_state%0d", i),     32'(dbg_state[i]), 32'(ST_IDLE));
    end
    check("rst_crc_value16", 32'(crc_value16), 32'h0);
    check("rst_crc_value32", crc_value32,      32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Test 1: check string on CRC16, no backpressure.
    load_check_string();
    check("model_crc16_check", model_crc(0), 32'h0000_FEE8);
    send_buf(0, 1'b0);
    drain();

    // Test 2: single-beat frame.
    frame_buf = {8'h01};
    send_buf(0, 1'b0);
    drain();

    // Test 3: check string and random frames with random backpressure and gaps.
    rand_ready = 1'b1;
    load_check_string();
    send_buf(0, 1'b1);
    repeat (6) begin
      load_random();
      send_buf(0, 1'b1);
    end
    drain();
    rand_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Test 4: back-to-back single-beat frames.
    frame_buf = {8'h00};
    send_buf(0, 1'b0);
    frame_buf = {8'h01};
    send_buf(0, 1'b0);
    drain();

    // Test 5: reset after the first CRC word is taken.
    load_check_string();
    send_buf(0, 1'b0);
    g = 0;
    do begin
      @(negedge clk); #2;
      g++;
    end while (exp_q0.size() != 1 && g < 100);
    check("abort_reach_crc_word", 32'(exp_q0.size()), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_out_valid", 32'(out_valid[0]), 32'h0);
    check("abort_crc_done",  32'(crc_done[0]),  32'h0);
    check("abort_crc_value", 32'(crc_value16),  32'h0);
    check("abort_state",     32'(dbg_state[0]), 32'(ST_IDLE));
    rst = 1'b0;
    exp_q0.delete();
    void'(exp_crc0.pop_back());
    frames_exp[0]--;
    @(posedge clk); #1;
    check("abort_no_second_word", 32'(out_valid[0]), 32'h0);
    load_check_string();
    send_buf(0, 1'b0);
    drain();

    // Test 6: CRC-32/BZIP2 instance, check string then random frames.
    load_check_string();
    check("model_crc32_check", model_crc(1), 32'hFC89_1918);
    send_buf(1, 1'b0);
    drain();
    rand_ready = 1'b1;
    repeat (4) begin
      load_random();
      send_buf(1, 1'b1);
    end
    drain();
    rand_ready = 1'b0;

    // One crc_done pulse per completed frame.
    check("done_count16", 32'(done_cnt[0]), 32'(frames_exp[0]));
    check("done_count32", 32'(done_cnt[1]), 32'(frames_exp[1]));
    check("crc_left16",   32'(exp_crc0.size()), 32'd0);
    check("crc_left32",   32'(exp_crc1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pes_crc_stream_gen
